// File: rtl/paddle_sampler.sv
// paddle_sampler: per-frame paddle capacitor dump and comparator capture.
// Publishes first-edge scanline positions at each vertical sync rise.
module paddle_sampler #(
  parameter int DUMP_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hpaddle,
  input  logic       vpaddle,
  input  logic       vsync,
  input  logic [8:0] vpos,
  output logic [7:0] paddle_x,
  output logic [7:0] paddle_y,
  output logic       x_timeout,
  output logic       y_timeout,
  output logic       sample_valid,
  output logic       dump
);

  typedef enum logic {
    ST_DUMP,
    ST_MEASURE
  } state_t;

  localparam logic [15:0] LAST = 16'(DUMP_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;

  logic h_s1, h_s2, h_prev;
  logic v_s1, v_s2, v_prev;
  logic vsync_q;

  logic       hx, hy;
  logic [7:0] cap_x, cap_y;

  logic       h_rise, v_rise, vs_rise;
  logic [7:0] vpos_sat;

  assign h_rise   = h_s2 & ~h_prev;
  assign v_rise   = v_s2 & ~v_prev;
  assign vs_rise  = vsync & ~vsync_q;
  assign vpos_sat = vpos[8] ? 8'hFF : vpos[7:0];
  assign dump     = (state == ST_DUMP);

  // Synchronize paddle pins and keep previous values for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_s1    <= 1'b0;
      h_s2    <= 1'b0;
      h_prev  <= 1'b0;
      v_s1    <= 1'b0;
      v_s2    <= 1'b0;
      v_prev  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      h_s1    <= hpaddle;
      h_s2    <= h_s1;
      h_prev  <= h_s2;
      v_s1    <= vpaddle;
      v_s2    <= v_s1;
      v_prev  <= v_s2;
      vsync_q <= vsync;
    end
  end

  // Frame FSM: dump window, first-edge capture and commit on vsync rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_DUMP;
      cnt          <= 16'd0;
      hx           <= 1'b0;
      hy           <= 1'b0;
      cap_x        <= 8'd0;
      cap_y        <= 8'd0;
      paddle_x     <= 8'd0;
      paddle_y     <= 8'd0;
      x_timeout    <= 1'b0;
      y_timeout    <= 1'b0;
      sample_valid <= 1'b0;
    end else if (vs_rise) begin
      // Same-cycle paddle rises are dropped; flags are used as they stood.
      paddle_x     <= hx ? cap_x : 8'hFF;
      paddle_y     <= hy ? cap_y : 8'hFF;
      x_timeout    <= ~hx;
      y_timeout    <= ~hy;
      sample_valid <= 1'b1;
      state        <= ST_DUMP;
      cnt          <= 16'd0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        ST_DUMP: begin
          if (cnt == LAST) begin
            state <= ST_MEASURE;
            cnt   <= 16'd0;
            hx    <= 1'b0;
            hy    <= 1'b0;
            cap_x <= 8'd0;
            cap_y <= 8'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_MEASURE: begin
          if (h_rise && !hx) begin
            cap_x <= vpos_sat;
            hx    <= 1'b1;
          end
          if (v_rise && !hy) begin
            cap_y <= vpos_sat;
            hy    <= 1'b1;
          end
        end
        default: begin
          state <= ST_DUMP;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_sampler.sv
// tb_paddle_sampler: scenario tasks plus randomized frames
// checked against a first-edge-per-frame reference model.
module tb_paddle_sampler;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       hpaddle;
  logic       vpaddle;
  logic       vsync;
  logic [8:0] vpos;
  logic [7:0] paddle_x;
  logic [7:0] paddle_y;
  logic       x_timeout;
  logic       y_timeout;
  logic       sample_valid;
  logic       dump;

  int passed = 0;
  int total  = 0;

  paddle_sampler #(.DUMP_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .hpaddle      (hpaddle),
    .vpaddle      (vpaddle),
    .vsync        (vsync),
    .vpos         (vpos),
    .paddle_x     (paddle_x),
    .paddle_y     (paddle_y),
    .x_timeout    (x_timeout),
    .y_timeout    (y_timeout),
    .sample_valid (sample_valid),
    .dump         (dump)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [19:0] obs();
    return {paddle_x, paddle_y, x_timeout, y_timeout, sample_valid, dump};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hpulse(input int v);
    vpos = 9'(v);
    hpaddle = 1'b1;
    step(4);
    hpaddle = 1'b0;
    step(3);
  endtask

  task automatic vpulse(input int v);
    vpos = 9'(v);
    vpaddle = 1'b1;
    step(4);
    vpaddle = 1'b0;
    step(3);
  endtask

  task automatic commit();
    vsync = 1'b1;
    step(1);
  endtask

  task automatic end_frame();
    vsync = 1'b0;
    step(D + 2);
  endtask

  task automatic test_reset();
    int n;
    logic [19:0] e;
    reset = 1'b1;
    step(1);
    e = {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL reset_state got %h want %h", obs(), e);
    else passed++;
    step(2);
    reset = 1'b0;
    n = 0;
    while (dump === 1'b1 && n < 20) begin
      n++;
      step(1);
    end
    total++;
    if (n !== D) $display("FAIL dump_window got %0d want %0d", n, D);
    else passed++;
  endtask

  task automatic test_basic();
    logic [19:0] e;
    hpulse(100);
    vpulse(37);
    vpos = 9'd5;
    commit();
    e = {8'd100, 8'd37, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL basic_commit got %h want %h", obs(), e);
    else passed++;
    step(1);
    total++;
    if (sample_valid !== 1'b0 || dump !== 1'b1)
      $display("FAIL strobe_width got sv=%b dump=%b want 0 1", sample_valid, dump);
    else passed++;
    end_frame();
  endtask

  task automatic test_timeout_sat();
    logic [19:0] e;
    hpulse(300);
    commit();
    e = {8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL timeout_sat got %h want %h", obs(), e);
    else passed++;
    end_frame();
  endtask

  task automatic test_first_edge();
    logic [19:0] e;
    vsync = 1'b1;
    step(1);
    vsync = 1'b0;
    hpaddle = 1'b1;
    step(1);
    hpaddle = 1'b0;
    step(D + 4);
    hpulse(50);
    hpulse(80);
    vpulse(12);
    commit();
    e = {8'd50, 8'd12, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL first_edge got %h want %h", obs(), e);
    else passed++;
    vsync = 1'b0;
    hpaddle = 1'b1;
    step(D + 4);
    commit();
    e = {8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL dump_mask_hold got %h want %h", obs(), e);
    else passed++;
    hpaddle = 1'b0;
    end_frame();
  endtask

  task automatic test_simultaneous();
    logic [19:0] e;
    hpulse(200);
    vpos = 9'd44;
    vpaddle = 1'b1;
    step(2);
    vsync = 1'b1;
    step(1);
    e = {8'd200, 8'd255, 1'b0, 1'b1, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL simul_edge got %h want %h", obs(), e);
    else passed++;
    end_frame();
    commit();
    e = {8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL simul_carry got %h want %h", obs(), e);
    else passed++;
    vpaddle = 1'b0;
    end_frame();
  endtask

  task automatic test_reset_mid();
    logic [19:0] e;
    hpulse(20);
    vpulse(30);
    commit();
    end_frame();
    hpulse(90);
    reset = 1'b1;
    step(2);
    e = {8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL reset_mid got %h want %h", obs(), e);
    else passed++;
    reset = 1'b0;
    step(D + 2);
    total++;
    if (dump !== 1'b0) $display("FAIL reset_mid_dump got %b want 0", dump);
    else passed++;
    commit();
    e = {8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 1'b1};
    total++;
    if (obs() !== e) $display("FAIL reset_mid_commit got %h want %h", obs(), e);
    else passed++;
    end_frame();
  endtask

  task automatic test_random_frames();
    logic [19:0] e;
    int hr, vr, hv, vv, h2;
    logic [7:0] ex, ey;
    for (int f = 0; f < 12; f++) begin
      hr = int'($urandom_range(0, 1));
      vr = int'($urandom_range(0, 1));
      hv = int'($urandom_range(0, 511));
      vv = int'($urandom_range(0, 511));
      h2 = int'($urandom_range(0, 511));
      if (vr != 0) vpulse(vv);
      if (hr != 0) begin
        hpulse(hv);
        if ($urandom_range(0, 1) == 1) hpulse(h2);
      end
      vpos = 9'($urandom_range(0, 511));
      ex = (hr != 0) ? sat(hv) : 8'd255;
      ey = (vr != 0) ? sat(vv) : 8'd255;
      commit();
      e = {ex, ey, (hr == 0), (vr == 0), 1'b1, 1'b1};
      total++;
      if (obs() !== e) $display("FAIL rand_frame%0d got %h want %h", f, obs(), e);
      else passed++;
      end_frame();
    end
  endtask

  initial begin
    reset   = 1'b1;
    hpaddle = 1'b0;
    vpaddle = 1'b0;
    vsync   = 1'b0;
    vpos    = 9'd0;
    test_reset();
    test_basic();
    test_timeout_sat();
    test_first_edge();
    test_simultaneous();
    test_reset_mid();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
